// File: rtl/country_road_monitor.sv
// country_road_monitor: country-road car queue with a green-light drain FSM and a light-protocol checker.
// Defining MON_VIOL_COUNT_EN adds a saturating viol_count output.
module country_road_monitor #(
  parameter int CNT_W        = 4,
  parameter int DRAIN_CYCLES = 2,
  parameter int Y2RDELAY     = 3
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             car_arrive,
  input  logic [1:0]       highway,
  input  logic [1:0]       country,
  output logic             x,
  output logic [CNT_W-1:0] car_count,
  output logic             car_depart,
  output logic             overflow,
  output logic             violation,
`ifdef MON_VIOL_COUNT_EN
  output logic [7:0]       viol_count,
`endif
  output logic [2:0]       viol_code
);
  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] GREEN  = 2'd2;
  localparam logic [1:0] ILL    = 2'd3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [3:0] DRAIN_LD = 4'(DRAIN_CYCLES - 1);
  localparam logic [2:0] Y2R = 3'(Y2RDELAY);
  typedef enum logic {IDLE, PASS} state_t;
  state_t           state_q, state_d;
  logic [3:0]       tmr_q, tmr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dep_q, dep_d;
  logic             ovf_q, ovf_d;
  logic             vio_q, vio_d;
  logic [2:0]       code_q, code_d;
  logic [1:0]       phw_q, phw_d, pcn_q, pcn_d;
  logic             pv_q, pv_d;
  logic [2:0]       yh_q, yh_d, yc_q, yc_d;
  logic [2:0]       cur_code;
  always_comb begin
    dep_d   = state_q == PASS && country == GREEN && tmr_q == 4'd0;
    state_d = state_q;
    tmr_d   = tmr_q;
    if (state_q == IDLE) begin
      if (country == GREEN && cnt_q != '0) begin
        state_d = PASS;
        tmr_d   = DRAIN_LD;
      end
    end else if (country != GREEN || dep_d) begin
      state_d = IDLE;
    end else begin
      tmr_d = tmr_q - 4'd1;
    end
  end
  // a simultaneous arrival and departure leaves the queue untouched, even when full
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (car_arrive && !dep_d) begin
      if (cnt_q == CNT_MAX) ovf_d = 1'b1;
      else cnt_d = cnt_q + 1'b1;
    end else if (!car_arrive && dep_d) begin
      cnt_d = cnt_q - 1'b1;
    end
  end
  always_comb begin
    cur_code = !pv_q ? 3'd0 :
               (highway != RED && country != RED) ? 3'd1 :
               (highway == ILL || country == ILL) ? 3'd2 :
               ((phw_q == GREEN && highway == RED) || (pcn_q == GREEN && country == RED)) ? 3'd3 :
               ((phw_q == RED && highway == YELLOW) || (pcn_q == RED && country == YELLOW)) ? 3'd4 :
               ((phw_q == YELLOW && highway == RED && yh_q < Y2R) ||
                (pcn_q == YELLOW && country == RED && yc_q < Y2R)) ? 3'd5 : 3'd0;
    vio_d  = vio_q | (cur_code != 3'd0);
    code_d = vio_q ? code_q : cur_code;
    yh_d   = highway != YELLOW ? 3'd0 : (yh_q == 3'd7 ? 3'd7 : yh_q + 3'd1);
    yc_d   = country != YELLOW ? 3'd0 : (yc_q == 3'd7 ? 3'd7 : yc_q + 3'd1);
    phw_d  = highway;
    pcn_d  = country;
    pv_d   = 1'b1;
  end
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      cnt_q   <= '0;
      dep_q   <= 1'b0;
      ovf_q   <= 1'b0;
      vio_q   <= 1'b0;
      code_q  <= '0;
      phw_q   <= RED;
      pcn_q   <= RED;
      pv_q    <= 1'b0;
      yh_q    <= '0;
      yc_q    <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      dep_q   <= dep_d;
      ovf_q   <= ovf_d;
      vio_q   <= vio_d;
      code_q  <= code_d;
      phw_q   <= phw_d;
      pcn_q   <= pcn_d;
      pv_q    <= pv_d;
      yh_q    <= yh_d;
      yc_q    <= yc_d;
    end
  end
`ifdef MON_VIOL_COUNT_EN
  logic [7:0] vc_q, vc_d;
  always_comb vc_d = (cur_code != 3'd0 && vc_q != 8'hFF) ? vc_q + 8'd1 : vc_q;
  always_ff @(posedge clock) begin
    if (clear) vc_q <= '0;
    else vc_q <= vc_d;
  end
  assign viol_count = vc_q;
`endif
  assign x          = cnt_q != '0;
  assign car_count  = cnt_q;
  assign car_depart = dep_q;
  assign overflow   = ovf_q;
  assign violation  = vio_q;
  assign viol_code  = code_q;
endmodule
